apb_reg_slave: RTL

APB_REG_SLAVE -- requirements
Module: apb_reg_slave

---
 rtl/apb_reg_pkg.sv | 39 +++
 rtl/apb_reg_bank.sv | 57 +++++
 rtl/apb_reg_slave.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/apb_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_reg_pkg
//  Description : Shared constants for the APB register slave: register
//                offsets, FSM state encoding and the default ID word.
//  Revision    : 1.0  initial release
// ============================================================================
package apb_reg_pkg;

    // Register offsets within the 4 KB window
    localparam logic [11:0] OFS_R0     = 12'h000;
    localparam logic [11:0] OFS_R1     = 12'h004;
    localparam logic [11:0] OFS_R2     = 12'h008;
    localparam logic [11:0] OFS_R3     = 12'h00C;
    localparam logic [11:0] OFS_R4     = 12'h010;
    localparam logic [11:0] OFS_R5     = 12'h014;
    localparam logic [11:0] OFS_R6     = 12'h018;
    localparam logic [11:0] OFS_R7     = 12'h01C;
    localparam logic [11:0] OFS_ID     = 12'h020;
    localparam logic [11:0] OFS_STATUS = 12'h024;
    localparam logic [11:0] OFS_CYCLE  = 12'h028;
    localparam logic [11:0] OFS_WRCNT  = 12'h02C;
    localparam logic [11:0] OFS_LAST   = OFS_WRCNT;

    // Access FSM encoding (only used when wait states are built in)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Default identification word ("UARB")
    localparam logic [31:0] ID_VALUE_DEFAULT = 32'h5541_5242;

    // Writable offsets are the eight general registers; everything above is read-only
    function automatic logic ofs_is_rw(input logic [11:0] ofs);
        return (ofs <= OFS_R7);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : apb_reg_bank
//  Description : Eight 32-bit RW registers with indexed write port and the
//                full read multiplexer (R0-R7, ID, STATUS, CYCLE, WRCNT).
//  Revision    : 1.0  initial release
// ============================================================================
module apb_reg_bank
    import apb_reg_pkg::*;
(
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        wr_en_i,
    input  logic [2:0]  wr_idx_i,
    input  logic [31:0] wr_data_i,
    input  logic [11:0] rd_ofs_i,
    input  logic [31:0] id_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cycle_i,
    input  logic [31:0] wrcnt_i,
    output logic [31:0] rd_data_o,
    output logic [31:0] r0_o
);

    logic [31:0] regs_q [8];

    // Register file: cleared by reset, one word written per committed access
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            regs_q[wr_idx_i] <= wr_data_i;
        end
    end

    // Read mux; unmapped offsets read as zero (the error path masks them anyway)
    always_comb begin
        rd_data_o = '0;
        if (rd_ofs_i <= OFS_R7) begin
            rd_data_o = regs_q[rd_ofs_i[4:2]];
        end else begin
            case (rd_ofs_i)
                OFS_ID:     rd_data_o = id_i;
                OFS_STATUS: rd_data_o = status_i;
                OFS_CYCLE:  rd_data_o = cycle_i;
                OFS_WRCNT:  rd_data_o = wrcnt_i;
                default:    rd_data_o = '0;
            endcase
        end
    end

    assign r0_o = regs_q[0];

endmodule
`default_nettype wire

// File: rtl/apb_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module      : apb_reg_slave
//  Description : APB register slave: 8 RW registers, ID/STATUS/CYCLE/WRCNT
//                read-only words, error reporting on PSLVERR.
//                Build macro APB_REG_SLAVE_WAIT_EN adds the IDLE/WAIT/DONE
//                access FSM with WAIT_CYCLES wait states; without it every
//                access completes in its first enable cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module apb_reg_slave
    import apb_reg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic [31:0] i_status,
    output logic [31:0] o_ctrl
);

    // Transfer as seen by the decode/commit logic (captured or live)
    logic [31:0] xfer_addr;
    logic [31:0] xfer_wdata;
    logic        xfer_write;
    logic        xfer_done;

    logic [11:0] ofs;
    logic        hit;
    logic        err;
    logic        commit;
    logic [31:0] rd_data;
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] wrcnt_q, wrcnt_d;

`ifdef APB_REG_SLAVE_WAIT_EN
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    logic [1:0]  state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [31:0] addr_q, wdata_q;
    logic        write_q;
    logic        pready_q;

    // Next-state: zero wait states go straight to DONE so PREADY lands in A+1
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (PSEL && PENABLE) begin
                    wcnt_d  = WAIT_LOAD;
                    state_d = (WAIT_LOAD == 4'd0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!PSEL) begin
                    state_d = ST_IDLE;
                    wcnt_d  = '0;
                end else begin
                    wcnt_d = (wcnt_q == 4'd0) ? 4'd0 : wcnt_q - 4'd1;
                    if (wcnt_q <= 4'd1) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                wcnt_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                wcnt_d  = '0;
            end
        endcase
    end

    // FSM, wait counter and registered PREADY (high exactly while in DONE)
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= ST_IDLE;
            wcnt_q   <= '0;
            pready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            pready_q <= (state_d == ST_DONE);
        end
    end

    // Latch the request at access start; the bus may change afterwards
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else if (state_q == ST_IDLE && PSEL && PENABLE) begin
            addr_q  <= PADDR;
            wdata_q <= PWDATA;
            write_q <= PWRITE;
        end
    end

    assign xfer_addr  = addr_q;
    assign xfer_wdata = wdata_q;
    assign xfer_write = write_q;
    assign xfer_done  = (state_q == ST_DONE);
    assign PREADY     = pready_q;
`else
    logic [3:0] unused_wait_cycles;
    assign unused_wait_cycles = 4'(WAIT_CYCLES);

    assign xfer_addr  = PADDR;
    assign xfer_wdata = PWDATA;
    assign xfer_write = PWRITE;
    assign xfer_done  = PSEL && PENABLE;
    assign PREADY     = 1'b1;
`endif

    assign ofs    = xfer_addr[11:0];
    assign hit    = (xfer_addr[31:12] == BASE_ADDR[31:12]);
    assign err    = !hit || (ofs > OFS_LAST) || (xfer_addr[1:0] != 2'b00)
                    || (xfer_write && !ofs_is_rw(ofs));
    assign commit = xfer_done && !err && xfer_write;

    assign PSLVERR = xfer_done && err;
    assign PRDATA  = (xfer_done && !err && !xfer_write) ? rd_data : '0;

    // Free-running cycle counter wraps; write counter saturates
    always_comb begin
        cycle_d = cycle_q + 32'd1;
        wrcnt_d = wrcnt_q;
        if (commit && (wrcnt_q != 32'hFFFF_FFFF)) begin
            wrcnt_d = wrcnt_q + 32'd1;
        end
    end

    // Counter state
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cycle_q <= '0;
            wrcnt_q <= '0;
        end else begin
            cycle_q <= cycle_d;
            wrcnt_q <= wrcnt_d;
        end
    end

    apb_reg_bank u_bank (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .wr_en_i   (commit),
        .wr_idx_i  (xfer_addr[4:2]),
        .wr_data_i (xfer_wdata),
        .rd_ofs_i  (ofs),
        .id_i      (ID_VALUE),
        .status_i  (i_status),
        .cycle_i   (cycle_q),
        .wrcnt_i   (wrcnt_q),
        .rd_data_o (rd_data),
        .r0_o      (o_ctrl)
    );

endmodule
`default_nettype wire
